// File: rtl/pre_decode_pkg.sv
// pre_decode_pkg: shared frontend types, opcodes and helpers for the predecode stage
`ifndef FTQ_SIZE
`define FTQ_SIZE 64
`endif
package pre_decode_pkg;
    localparam int FETCH_INSTS  = 16;
    localparam int IQ_DEPTH     = 32;
    localparam int DECODE_WIDTH = 4;
    localparam int FTQ_SIZE     = `FTQ_SIZE;
    localparam int FTQ_W        = $clog2(FTQ_SIZE);
    localparam int OFS_W        = $clog2(FETCH_INSTS);
    localparam int IQ_W         = $clog2(IQ_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef logic [FTQ_W-1:0] ftqIdx_t;
    typedef logic [31:0] addr_t;
    typedef enum logic {RUN, RECOVER} state_t;

    typedef struct packed {
        addr_t      startAddr;
        logic [6:0] fetchBlock_size;
        logic       taken;
        addr_t      nextAddr;
    } ftq2icacheInfo_t;

    typedef struct packed {
        logic [5:0] rob_idx;
        logic       taken;
        logic       mispred;
        ftqIdx_t    ftq_idx;
        addr_t      branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic [31:0]      inst;
        addr_t            pc;
        ftqIdx_t          ftqIdx;
        logic [OFS_W-1:0] ftqOffset;
    } preDecInst_t;

    function automatic addr_t jal_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic ftqIdx_t ftq_inc(input ftqIdx_t idx);
        return (idx == ftqIdx_t'(FTQ_SIZE - 1)) ? '0 : idx + ftqIdx_t'(1);
    endfunction
endpackage

// File: rtl/pre_decode_scan.sv
// pre_decode_scan: classifies fetch-block slots and resolves false-prediction rules and npc
module pre_decode_scan
    import pre_decode_pkg::*;
(
    input  ftq2icacheInfo_t              info,
    input  logic [FETCH_INSTS-1:0][31:0] insts,
    output logic                         falsepred,
    output addr_t                        npc,
    output logic [OFS_W:0]               cnt
);
    logic [OFS_W:0]   n;
    logic [OFS_W-1:0] last, jal_slot;
    logic             jal_found;
    logic [6:0]       last_op;
    addr_t            fall, jal_tgt, last_tgt;
    logic             r1, r2, r3, r4;

    always_comb begin
        n = info.fetchBlock_size[6:2];
        last = OFS_W'(n - (OFS_W+1)'(1));
        jal_found = 1'b0;
        jal_slot = '0;
        // descending scan leaves the earliest jal selected
        for (int k = FETCH_INSTS - 1; k >= 0; k--)
            if (k < int'(n) && insts[k][6:0] == OP_JAL) begin
                jal_found = 1'b1;
                jal_slot = OFS_W'(k);
            end
        last_op = insts[last][6:0];
        fall = info.startAddr + addr_t'(info.fetchBlock_size);
        jal_tgt = info.startAddr + addr_t'({jal_slot, 2'b00}) + jal_imm(insts[jal_slot]);
        last_tgt = info.startAddr + addr_t'({last, 2'b00}) + jal_imm(insts[last]);
        r1 = jal_found && (jal_slot != last || !info.taken);
        r2 = info.taken && !(last_op inside {OP_JAL, OP_JALR, OP_BRANCH});
        r3 = info.taken && last_op == OP_JAL && last_tgt != info.nextAddr;
        r4 = !info.taken && info.nextAddr != fall;
        falsepred = r1 || r2 || r3 || r4;
        npc = r1 ? jal_tgt : r3 ? last_tgt : fall;
        cnt = r1 ? {1'b0, jal_slot} + (OFS_W+1)'(1) : n;
    end
endmodule

// File: rtl/pre_decode.sv
// pre_decode: captures fetch blocks, flags BPU false predictions/stalls to the FTQ
// and buffers predecoded instructions for decode.
module pre_decode
    import pre_decode_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_squash_vld,
    input  ftqIdx_t                            i_squash_ftqIdx,
    input  logic                               i_fetch_vld,
    output logic                               o_fetch_rdy,
    input  ftqIdx_t                            i_fetch_ftqIdx,
    input  ftq2icacheInfo_t                    i_fetch_info,
    input  logic [FETCH_INSTS-1:0][31:0]       i_fetch_insts,
    output logic                               o_falsepred,
    output logic                               o_stall,
    output ftqIdx_t                            o_recovery_idx,
    output branchwbInfo_t                      o_preDecodewbInfo,
    output logic [DECODE_WIDTH-1:0]            o_inst_vld,
    output preDecInst_t [DECODE_WIDTH-1:0]     o_inst,
    input  logic                               i_decode_rdy
);
    state_t                       state, state_nxt;
    ftqIdx_t                      expected_idx, s1_idx;
    logic                         s1_vld;
    ftq2icacheInfo_t              s1_info;
    logic [FETCH_INSTS-1:0][31:0] s1_insts;
    preDecInst_t                  iq [IQ_DEPTH];
    logic [IQ_W-1:0]              head, tail;
    logic [IQ_W:0]                count, enq_n, deq_n;
    logic [OFS_W:0]               s1_cnt, scan_cnt;
    logic                         scan_fp, s1_fp, room_ok, idx_hit, capture, stall_ev, fp_ev;
    addr_t                        scan_npc;
    branchwbInfo_t                wb;

    pre_decode_scan u_scan (
        .info      (s1_info),
        .insts     (s1_insts),
        .falsepred (scan_fp),
        .npc       (scan_npc),
        .cnt       (scan_cnt)
    );

    always_comb begin
        s1_fp = s1_vld && scan_fp;
        s1_cnt = s1_vld ? s1_info.fetchBlock_size[6:2] : '0;
        // room is judged without credit for a same-cycle decode pop
        room_ok = (IQ_DEPTH - int'(count) - int'(s1_cnt)) >= FETCH_INSTS;
        idx_hit = i_fetch_vld && state == RUN && i_fetch_ftqIdx == expected_idx;
        capture = idx_hit && room_ok && !i_squash_vld && !s1_fp;
        stall_ev = idx_hit && !room_ok && !i_squash_vld && !s1_fp;
        fp_ev = s1_fp && !i_squash_vld;
        o_fetch_rdy = rst && state == RUN && room_ok && !s1_fp;
        enq_n = (s1_vld && !i_squash_vld) ? (IQ_W+1)'(scan_cnt) : '0;
        deq_n = !i_decode_rdy ? '0 : (count < (IQ_W+1)'(DECODE_WIDTH)) ? count : (IQ_W+1)'(DECODE_WIDTH);
        wb = '0;
        wb.ftq_idx = s1_idx;
        wb.branch_npc = scan_npc;
    end

    always_comb state_nxt = (fp_ev || stall_ev) ? RECOVER : RUN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            expected_idx <= '0;
            s1_vld <= 1'b0;
            head <= '0;
            tail <= '0;
            count <= '0;
            o_falsepred <= 1'b0;
            o_stall <= 1'b0;
            o_recovery_idx <= '0;
            o_preDecodewbInfo <= '0;
        end else begin
            state <= state_nxt;
            s1_vld <= capture;
            o_falsepred <= fp_ev;
            o_stall <= stall_ev;
            if (i_squash_vld) begin
                expected_idx <= i_squash_ftqIdx;
                head <= '0;
                tail <= '0;
                count <= '0;
            end else begin
                expected_idx <= fp_ev ? ftq_inc(s1_idx) : capture ? ftq_inc(expected_idx) : expected_idx;
                head <= head + IQ_W'(deq_n);
                tail <= tail + IQ_W'(enq_n);
                count <= count + enq_n - deq_n;
            end
            if (fp_ev) begin
                o_recovery_idx <= ftq_inc(s1_idx);
                o_preDecodewbInfo <= wb;
            end else if (stall_ev) begin
                o_recovery_idx <= expected_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            s1_idx <= i_fetch_ftqIdx;
            s1_info <= i_fetch_info;
            s1_insts <= i_fetch_insts;
        end
        for (int k = 0; k < FETCH_INSTS; k++)
            if (k < int'(enq_n))
                iq[tail + IQ_W'(k)] <= '{inst: s1_insts[k], pc: s1_info.startAddr + addr_t'(4 * k),
                                         ftqIdx: s1_idx, ftqOffset: OFS_W'(k)};
    end

    always_comb begin
        o_inst_vld = '0;
        o_inst = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            o_inst_vld[k] = k < int'(count);
            o_inst[k] = o_inst_vld[k] ? iq[head + IQ_W'(k)] : '0;
        end
    end
endmodule

// File: tb/tb_pre_decode.sv
// tb_pre_decode: directed vectors with hand-computed expectations for pre_decode
module tb_pre_decode;
    import pre_decode_pkg::*;

    logic                           clk, rst;
    logic                           i_squash_vld, i_fetch_vld, o_fetch_rdy, i_decode_rdy;
    ftqIdx_t                        i_squash_ftqIdx, i_fetch_ftqIdx, o_recovery_idx;
    ftq2icacheInfo_t                i_fetch_info;
    logic [FETCH_INSTS-1:0][31:0]   i_fetch_insts, insts;
    logic                           o_falsepred, o_stall;
    branchwbInfo_t                  o_preDecodewbInfo;
    logic [DECODE_WIDTH-1:0]        o_inst_vld;
    preDecInst_t [DECODE_WIDTH-1:0] o_inst;
    int                             total = 0, bad = 0;

    pre_decode dut (
        .clk               (clk),
        .rst               (rst),
        .i_squash_vld      (i_squash_vld),
        .i_squash_ftqIdx   (i_squash_ftqIdx),
        .i_fetch_vld       (i_fetch_vld),
        .o_fetch_rdy       (o_fetch_rdy),
        .i_fetch_ftqIdx    (i_fetch_ftqIdx),
        .i_fetch_info      (i_fetch_info),
        .i_fetch_insts     (i_fetch_insts),
        .o_falsepred       (o_falsepred),
        .o_stall           (o_stall),
        .o_recovery_idx    (o_recovery_idx),
        .o_preDecodewbInfo (o_preDecodewbInfo),
        .o_inst_vld        (o_inst_vld),
        .o_inst            (o_inst),
        .i_decode_rdy      (i_decode_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops();
        for (int k = 0; k < FETCH_INSTS; k++) insts[k] = 32'h0000_0013;
    endtask

    task automatic send(input int idx, input logic [31:0] sa, input int sz, input logic tk, input logic [31:0] na);
        i_fetch_vld = 1'b1;
        i_fetch_ftqIdx = ftqIdx_t'(idx);
        i_fetch_info.startAddr = sa;
        i_fetch_info.fetchBlock_size = 7'(sz);
        i_fetch_info.taken = tk;
        i_fetch_info.nextAddr = na;
        i_fetch_insts = insts;
        tick();
        i_fetch_vld = 1'b0;
    endtask

    task automatic pop();
        i_decode_rdy = 1'b1;
        tick();
        i_decode_rdy = 1'b0;
    endtask

    task automatic squash(input int idx);
        i_squash_vld = 1'b1;
        i_squash_ftqIdx = ftqIdx_t'(idx);
        tick();
        i_squash_vld = 1'b0;
    endtask

    task automatic chk_fp(input string tag, input int rec, input int fidx, input logic [31:0] npc);
        chk({tag, "_fp"}, o_falsepred, 1);
        chk({tag, "_rec"}, o_recovery_idx, rec);
        chk({tag, "_wbidx"}, o_preDecodewbInfo.ftq_idx, fidx);
        chk({tag, "_npc"}, o_preDecodewbInfo.branch_npc, npc);
        chk({tag, "_stall"}, o_stall, 0);
    endtask

    initial begin
        rst = 1'b0;
        i_squash_vld = 1'b0;
        i_squash_ftqIdx = '0;
        i_fetch_vld = 1'b0;
        i_fetch_ftqIdx = '0;
        i_fetch_info = '0;
        i_fetch_insts = '0;
        i_decode_rdy = 1'b0;
        nops();
        #3;
        chk("rst_rdy", o_fetch_rdy, 0);
        chk("rst_vld", o_inst_vld, 0);
        chk("rst_fp", o_falsepred, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb", o_preDecodewbInfo, 0);
        rst = 1'b1;
        tick();
        chk("run_rdy", o_fetch_rdy, 1);

        // plain 4-instruction block
        send(0, 32'h1000, 16, 1'b0, 32'h1010);
        tick();
        chk("b0_vld", o_inst_vld, 4'hF);
        chk("b0_pc0", o_inst[0].pc, 32'h1000);
        chk("b0_pc3", o_inst[3].pc, 32'h100C);
        chk("b0_ofs2", o_inst[2].ftqOffset, 2);
        chk("b0_inst1", o_inst[1].inst, 32'h13);
        chk("b0_fp", o_falsepred, 0);
        pop();
        chk("b0_drain", o_inst_vld, 0);

        // wrong-path idx dropped, then expected idx 1 accepted
        send(2, 32'h1010, 4, 1'b0, 32'h1014);
        tick();
        chk("wp_vld", o_inst_vld, 0);
        send(1, 32'h1010, 4, 1'b0, 32'h1014);
        tick();
        chk("b1_vld", o_inst_vld, 4'h1);
        chk("b1_pc", o_inst[0].pc, 32'h1010);
        chk("b1_idx", o_inst[0].ftqIdx, 1);
        pop();
        squash(3);

        // rule 1: unpredicted jal at slot 2, truncation, next block dropped
        nops();
        insts[2] = 32'h0400_00EF;
        send(3, 32'h2000, 32, 1'b0, 32'h2020);
        chk("r1_rdy_s1", o_fetch_rdy, 0);
        i_fetch_vld = 1'b1;
        i_fetch_ftqIdx = ftqIdx_t'(4);
        tick();
        chk_fp("r1", 4, 3, 32'h2048);
        chk("r1_vld", o_inst_vld, 4'h7);
        chk("r1_jal", o_inst[2].inst, 32'h0400_00EF);
        chk("r1_rdy_rec", o_fetch_rdy, 0);
        i_fetch_vld = 1'b0;
        tick();
        chk("r1_pulse_end", o_falsepred, 0);
        tick();
        chk("r1_drop4", o_inst_vld, 4'h7);
        pop();

        // rule 2: phantom taken
        nops();
        send(4, 32'h2048, 8, 1'b1, 32'h5000);
        tick();
        chk_fp("r2", 5, 4, 32'h2050);
        chk("r2_vld", o_inst_vld, 4'h3);
        tick();
        pop();

        // rule 3: taken jal whose target disagrees with nextAddr
        nops();
        insts[1] = 32'h0040_006F;
        send(5, 32'h2FF8, 8, 1'b1, 32'h3004);
        tick();
        chk_fp("r3", 6, 5, 32'h3000);
        tick();
        pop();

        // rule 4: bad fallthrough
        nops();
        send(6, 32'h4000, 4, 1'b0, 32'h4008);
        tick();
        chk_fp("r4", 7, 6, 32'h4004);
        tick();
        pop();

        // taken branch at the end is never target-checked
        nops();
        insts[1] = 32'h0000_0063;
        send(7, 32'h2FF8, 8, 1'b1, 32'h9999_0000);
        tick();
        chk("br_fp", o_falsepred, 0);
        chk("br_vld", o_inst_vld, 4'h3);
        chk("br_inst", o_inst[1].inst, 32'h63);
        pop();

        // jal in last slot, not taken: rule 1 target beats rule 4 fallthrough
        nops();
        insts[0] = 32'h0400_00EF;
        send(8, 32'h5000, 4, 1'b0, 32'h5008);
        tick();
        chk_fp("prio", 9, 8, 32'h5040);
        tick();
        pop();

        // stall: IQ at 20 entries, idx 5 refused then accepted after a pop
        squash(3);
        nops();
        send(3, 32'h6000, 64, 1'b0, 32'h6040);
        send(4, 32'h6040, 16, 1'b0, 32'h6050);
        tick();
        chk("fill_vld", o_inst_vld, 4'hF);
        chk("fill_rdy", o_fetch_rdy, 0);
        send(5, 32'h6050, 16, 1'b0, 32'h6060);
        chk("st_stall", o_stall, 1);
        chk("st_rec", o_recovery_idx, 5);
        chk("st_fp", o_falsepred, 0);
        tick();
        chk("st_pulse_end", o_stall, 0);
        pop();
        chk("st_rdy_after_pop", o_fetch_rdy, 1);
        send(5, 32'h6050, 16, 1'b0, 32'h6060);
        tick();
        chk("st_head_pc", o_inst[0].pc, 32'h6010);
        chk("st_cap_rdy", o_fetch_rdy, 0);
        chk("st_cap_stall", o_stall, 0);

        // recovery index wraps past the last FTQ entry
        squash(FTQ_SIZE - 1);
        nops();
        insts[0] = 32'h0400_00EF;
        send(FTQ_SIZE - 1, 32'h7000, 4, 1'b0, 32'h7004);
        tick();
        chk_fp("wrap", 0, FTQ_SIZE - 1, 32'h7040);
        chk("wrap_vld", o_inst_vld, 4'h1);
        tick();

        // squash while s1 holds a would-be falsepred
        nops();
        send(0, 32'h8000, 4, 1'b0, 32'h9000);
        squash(7);
        chk("sq_fp", o_falsepred, 0);
        chk("sq_vld", o_inst_vld, 0);
        send(7, 32'h8000, 4, 1'b0, 32'h8004);
        tick();
        chk("sq_new_vld", o_inst_vld, 4'h1);
        chk("sq_new_pc", o_inst[0].pc, 32'h8000);
        chk("sq_new_idx", o_inst[0].ftqIdx, 7);

        // asynchronous reset mid-enqueue
        send(8, 32'h8004, 16, 1'b0, 32'h8014);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", o_inst_vld, 0);
        chk("arst_pc", o_inst[0].pc, 0);
        chk("arst_rdy", o_fetch_rdy, 0);
        chk("arst_fp", o_falsepred, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pre_decode.md
Name: pre_decode

Overview:
- Frontend stage directly downstream of the FTQ→icache fetch path.
- Accepts each fetched block with its ftqIdx and predicted boundary, then scans the 32-bit instructions for control flow.
- Detects BPU false predictions and reports them to the FTQ as falsepred, recovery index and corrected npc.
- Raises stall when the instruction queue cannot absorb a block; otherwise buffers instructions for decode.

Parameters:
FETCH_INSTS, 16, max instructions per fetch block (64 bytes, 4-byte slots; RVC not supported)
IQ_DEPTH, 32, instruction queue entries (power of two, >= 2*FETCH_INSTS)
DECODE_WIDTH, 4, instructions presented to decode per cycle
FTQ_SIZE, `FTQ_SIZE, FTQ entries; ftqIdx_t width = clog2(FTQ_SIZE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_squash_vld  in  1  backend squash
i_squash_ftqIdx  in  ftqIdx_t  FTQ restart index after squash
i_fetch_vld  in  1  fetched block valid
o_fetch_rdy  out  1  block capturable this cycle
i_fetch_ftqIdx  in  ftqIdx_t  block's FTQ index
i_fetch_info  in  ftq2icacheInfo_t  startAddr, fetchBlock_size (bytes, multiple of 4, 4..64), taken, nextAddr
i_fetch_insts  in  32 x FETCH_INSTS  instruction words, slot k at startAddr+4k
o_falsepred  out  1  false prediction pulse to FTQ
o_stall  out  1  block dropped for lack of room, pulse to FTQ
o_recovery_idx  out  ftqIdx_t  index the FTQ refetches from
o_preDecodewbInfo  out  branchwbInfo_t  ftq_idx and branch_npc; all other fields 0
o_inst_vld  out  DECODE_WIDTH  per-lane valid
o_inst  out  DECODE_WIDTH x preDecInst_t  inst, pc, ftqIdx, ftqOffset
i_decode_rdy  in  1  decode pops all valid lanes

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, expected_idx=0, IQ empty, s1 empty, state RUN.

Capture (cycle T):
- Block captured into s1 iff i_fetch_vld && state==RUN && ftqIdx==expected_idx && room_ok && !i_squash_vld && !s1_falsepred.
- room_ok = (IQ_DEPTH - iq_count - s1_cnt) >= FETCH_INSTS; no credit is taken for same-cycle dequeue.
- o_fetch_rdy = state==RUN && room_ok && !s1_falsepred.
- Blocks with ftqIdx != expected_idx are dropped silently as wrong path.
- On capture, expected_idx advances by 1, wrapping FTQ_SIZE-1 -> 0.

Check (cycle T+1, s1 combinational):
- Valid slots: k < size/4.
- jal = opcode 1101111; jalr = 1100111; branch = 1100011.
- Rule 1, jal not predicted: the first jal at slot j (j < last, or j == last with taken==0) is a falsepred. Truncate the block to slots 0..j; npc = pc_j + sext(J-imm).
- Rule 2, phantom taken: taken==1 and the last slot is none of jal/jalr/branch. falsepred, npc = startAddr+size.
- Rule 3, wrong jal target: taken==1, last slot is jal, and its target != nextAddr. falsepred, npc = target.
- Rule 4, bad fallthrough: taken==0 and nextAddr != startAddr+size. falsepred, npc = startAddr+size.
- Priority: Rule 1 (earliest slot), then 2, 3, 4. jalr and branch targets are never checked.
- s1 slots are enqueued into the IQ at the end of T+1, truncated on Rule 1. ftqOffset = slot index.

Feedback (cycle T+2, outputs registered):
- On falsepred: o_falsepred=1, o_recovery_idx = ftqIdx+1 (wrapping), o_preDecodewbInfo = {ftq_idx=ftqIdx, branch_npc=npc}, expected_idx = ftqIdx+1.
- On stall (i_fetch_vld, state RUN, idx match, !room_ok): the block is dropped; next cycle o_stall=1 and o_recovery_idx = expected_idx.
- States: RUN and RECOVER.
  - falsepred or stall moves to RECOVER for exactly the cycle the pulse is visible; all input is dropped in that cycle.
  - RECOVER returns to RUN on the next cycle.
  - The icache flushes in-flight requests on o_falsepred|o_stall.
- Simultaneous falsepred and stall: falsepred wins; o_stall stays 0.

Squash:
- Clears s1 and the IQ, suppresses any pending falsepred/stall pulse, sets expected_idx = i_squash_ftqIdx, state RUN.
- Squash outranks every other event in the same cycle.

Instruction queue:
- Circular; enqueues up to FETCH_INSTS per cycle.
- Lane k valid iff k < iq_count.
- i_decode_rdy pops min(iq_count, DECODE_WIDTH).
- Enqueue and dequeue in the same cycle are both applied.
- Pointers wrap modulo IQ_DEPTH.

Decomposition:
- Shared frontend package: preDecInst_t, opcode constants, J-imm extraction function, ftqIdx increment-with-wrap function.
- Sub-module pre_decode_scan: combinational slot classification, rule priority and npc. The IQ stays inline.

Test Plan:
- Block idx 0, start 0x1000, size 16, taken 0, next 0x1010, no branches -> four instructions at decode in cycle T+2, o_falsepred stays 0, expected_idx becomes 1.
- Block idx 3, start 0x2000, size 32, jal +0x40 at slot 2, taken 0 -> o_falsepred=1, recovery_idx 4, branch_npc 0x2048, only 3 instructions enqueued; next-cycle block idx 4 dropped.
- Block size 8, taken 1, last slot addi -> falsepred, npc = start+8; block taken 1 with last slot jal target 0x3000 but next 0x3004 -> npc 0x3000.
- Fill the IQ to 20 with i_decode_rdy=0, present idx 5 -> o_stall=1, recovery_idx 5; raise rdy, re-present idx 5 -> captured.
- FTQ_SIZE-1 block with jal falsepred -> recovery_idx 0 (wrap); i_squash_vld with restart index 7 while s1 is full -> IQ empty, no pulse, next accepted idx 7.
- Assert rst mid-enqueue -> all outputs 0 immediately, without waiting for a clock edge.
